// File: rtl/sincos_scheduler.sv
// Shared sincos LUT scheduler.
// Round-robin arbitration of N_REQ angle requesters onto one combinational
// quarter-wave sine LUT. Each accepted request runs a cosine phase (the LUT
// is fed angle+90) and then a sine phase. The {cos, sin} pair and the
// requester ID are returned on a valid/ready response port.
//
// Ports (sincos_scheduler):
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid[N_REQ]     per-requester request valid
//   req_angle            packed angles in degrees, requester i at slice i
//   req_ready[N_REQ]     combinational grant, only in IDLE, one-hot or zero
//   rsp_valid/rsp_ready  response handshake
//   rsp_id               index of the requester served
//   rsp_cos, rsp_sin     signed results, 1.0 = 16384
//   rsp_err              request angle was >= 360

package angles;
    localparam int unsigned ANGLE_LENGTH = 9;
    localparam int unsigned OFFSET_BITS  = 14;
endpackage

// Combinational sine LUT over 0..359 degrees, quarter-wave table with
// quadrant folding. sin_sel=0 applies the +90 degree phase shift for cosine.
module sincos_lut
    import angles::*;
(
    input  logic [ANGLE_LENGTH-1:0]  angle,
    input  logic                     sin_sel,
    output logic [OFFSET_BITS+1:0]   value
);
    localparam int unsigned AW = ANGLE_LENGTH;
    localparam int unsigned RW = OFFSET_BITS + 2;
    localparam int unsigned MW = OFFSET_BITS + 1;

    // round(16384 * sin(deg)) for deg = 0..90
    function automatic logic [MW-1:0] quarter_sin(input logic [6:0] deg);
        case (deg)
            7'd0:  return MW'(0);     7'd1:  return MW'(286);   7'd2:  return MW'(572);   7'd3:  return MW'(857);
            7'd4:  return MW'(1143);  7'd5:  return MW'(1428);  7'd6:  return MW'(1713);  7'd7:  return MW'(1997);
            7'd8:  return MW'(2280);  7'd9:  return MW'(2563);  7'd10: return MW'(2845);  7'd11: return MW'(3126);
            7'd12: return MW'(3406);  7'd13: return MW'(3686);  7'd14: return MW'(3964);  7'd15: return MW'(4240);
            7'd16: return MW'(4516);  7'd17: return MW'(4790);  7'd18: return MW'(5063);  7'd19: return MW'(5334);
            7'd20: return MW'(5604);  7'd21: return MW'(5872);  7'd22: return MW'(6138);  7'd23: return MW'(6402);
            7'd24: return MW'(6664);  7'd25: return MW'(6924);  7'd26: return MW'(7182);  7'd27: return MW'(7438);
            7'd28: return MW'(7692);  7'd29: return MW'(7943);  7'd30: return MW'(8192);  7'd31: return MW'(8438);
            7'd32: return MW'(8682);  7'd33: return MW'(8923);  7'd34: return MW'(9162);  7'd35: return MW'(9397);
            7'd36: return MW'(9630);  7'd37: return MW'(9860);  7'd38: return MW'(10087); 7'd39: return MW'(10311);
            7'd40: return MW'(10531); 7'd41: return MW'(10749); 7'd42: return MW'(10963); 7'd43: return MW'(11174);
            7'd44: return MW'(11381); 7'd45: return MW'(11585); 7'd46: return MW'(11786); 7'd47: return MW'(11982);
            7'd48: return MW'(12176); 7'd49: return MW'(12365); 7'd50: return MW'(12551); 7'd51: return MW'(12733);
            7'd52: return MW'(12911); 7'd53: return MW'(13085); 7'd54: return MW'(13255); 7'd55: return MW'(13421);
            7'd56: return MW'(13583); 7'd57: return MW'(13741); 7'd58: return MW'(13894); 7'd59: return MW'(14044);
            7'd60: return MW'(14189); 7'd61: return MW'(14330); 7'd62: return MW'(14466); 7'd63: return MW'(14598);
            7'd64: return MW'(14726); 7'd65: return MW'(14849); 7'd66: return MW'(14968); 7'd67: return MW'(15082);
            7'd68: return MW'(15191); 7'd69: return MW'(15296); 7'd70: return MW'(15396); 7'd71: return MW'(15491);
            7'd72: return MW'(15582); 7'd73: return MW'(15668); 7'd74: return MW'(15749); 7'd75: return MW'(15826);
            7'd76: return MW'(15897); 7'd77: return MW'(15964); 7'd78: return MW'(16026); 7'd79: return MW'(16083);
            7'd80: return MW'(16135); 7'd81: return MW'(16182); 7'd82: return MW'(16225); 7'd83: return MW'(16262);
            7'd84: return MW'(16294); 7'd85: return MW'(16322); 7'd86: return MW'(16344); 7'd87: return MW'(16362);
            7'd88: return MW'(16374); 7'd89: return MW'(16382); 7'd90: return MW'(16384);
            default: return MW'(0);
        endcase
    endfunction

    logic [AW-1:0] eff_angle;
    logic [6:0]    idx;
    logic          neg;
    logic [MW-1:0] mag;

    // Phase shift for cosine, then fold into the first quadrant
    always_comb begin
        eff_angle = angle;
        if (!sin_sel) begin
            eff_angle = (angle >= AW'(270)) ? angle - AW'(270) : angle + AW'(90);
        end
        neg = 1'b0;
        idx = 7'(eff_angle);
        if (eff_angle <= AW'(90)) begin
            idx = 7'(eff_angle);
        end else if (eff_angle <= AW'(180)) begin
            idx = 7'(AW'(180) - eff_angle);
        end else if (eff_angle <= AW'(270)) begin
            idx = 7'(eff_angle - AW'(180));
            neg = 1'b1;
        end else begin
            idx = 7'(AW'(360) - eff_angle);
            neg = 1'b1;
        end
        mag   = quarter_sin(idx);
        value = neg ? RW'(-RW'(mag)) : RW'(mag);
    end
endmodule

module sincos_scheduler
    import angles::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ANGLE_LENGTH-1:0] req_angle,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [$clog2(N_REQ)-1:0]      rsp_id,
    output logic [OFFSET_BITS+1:0]        rsp_cos,
    output logic [OFFSET_BITS+1:0]        rsp_sin,
    output logic                          rsp_err
);
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned AW   = ANGLE_LENGTH;
    localparam int unsigned RW   = OFFSET_BITS + 2;

    typedef enum logic [1:0] {IDLE, COS, SIN, RESP} state_t;

    state_t          state, next_state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_lat;
    logic [AW-1:0]   angle_lat;
    logic [AW-1:0]   unit_angle;
    logic [RW-1:0]   cos_lat, sin_lat;
    logic            err_lat;
    logic [RW-1:0]   unit_value;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [AW-1:0]   grant_angle;
    logic            grant_bad;
    logic [AW-1:0]   grant_shift;
    int              scan_idx;

    logic accept, ld_cos, ld_sin, ld_rsp, rsp_fire;

    // Single shared LUT; its input is always a register
    sincos_lut u_lut (
        .angle   (unit_angle),
        .sin_sel (1'b1),
        .value   (unit_value)
    );

    // Round-robin search starting at rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_angle = '0;
        scan_idx    = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= int'(N_REQ)) begin
                scan_idx = scan_idx - int'(N_REQ);
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
                grant_angle = req_angle[scan_idx*int'(AW) +: AW];
            end
        end
        grant_bad   = (grant_angle >= AW'(360));
        grant_shift = (grant_angle >= AW'(270)) ? grant_angle - AW'(270)
                                                : grant_angle + AW'(90);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (grant_found) next_state = grant_bad ? RESP : COS;
            COS:  next_state = SIN;
            SIN:  next_state = RESP;
            RESP: if (rsp_valid && rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs: grant and datapath load strobes
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        ld_cos    = 1'b0;
        ld_sin    = 1'b0;
        ld_rsp    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                end
            end
            COS:  ld_cos = 1'b1;
            SIN:  ld_sin = 1'b1;
            RESP: begin
                if (!rsp_valid) begin
                    ld_rsp = 1'b1;
                end else if (rsp_ready) begin
                    rsp_fire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath: request latch, phase results, response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            id_lat     <= '0;
            angle_lat  <= '0;
            unit_angle <= '0;
            cos_lat    <= '0;
            sin_lat    <= '0;
            err_lat    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_cos    <= '0;
            rsp_sin    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                id_lat    <= grant_idx;
                angle_lat <= grant_angle;
                err_lat   <= grant_bad;
                if (grant_bad) begin
                    cos_lat <= '0;
                    sin_lat <= '0;
                end else begin
                    unit_angle <= grant_shift;
                end
            end
            if (ld_cos) begin
                cos_lat    <= unit_value;
                unit_angle <= angle_lat;
            end
            if (ld_sin) begin
                sin_lat <= unit_value;
            end
            if (ld_rsp) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_lat;
                rsp_cos   <= cos_lat;
                rsp_sin   <= sin_lat;
                rsp_err   <= err_lat;
            end
            if (rsp_fire) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sincos_scheduler.sv
// Scoreboard bench for sincos_scheduler: directed angles with hand-computed
// cos/sin values, round-robin order, back-pressure, error path and reset.
module tb_sincos_scheduler;
    import angles::*;

    localparam int unsigned N_REQ = 2;
    localparam int unsigned AW    = ANGLE_LENGTH;
    localparam int unsigned RW    = OFFSET_BITS + 2;

    typedef struct {
        int id;
        int cos_v;
        int sin_v;
        int err;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*AW-1:0]   req_angle;
    logic [N_REQ-1:0]      req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [0:0]            rsp_id;
    logic [RW-1:0]         rsp_cos;
    logic [RW-1:0]         rsp_sin;
    logic                  rsp_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   grant_log[$];
    exp_t mon_e;

    sincos_scheduler #(.N_REQ(N_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_angle (req_angle),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_cos   (rsp_cos),
        .rsp_sin   (rsp_sin),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare every completed response against the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d cos=%0d sin=%0d err=%0d, expected no response",
                         rsp_id, $signed(rsp_cos), $signed(rsp_sin), rsp_err);
            end else begin
                mon_e = sb.pop_front();
                if (int'(rsp_id) != mon_e.id || int'($signed(rsp_cos)) != mon_e.cos_v ||
                    int'($signed(rsp_sin)) != mon_e.sin_v || int'(rsp_err) != mon_e.err) begin
                    errors++;
                    $display("FAIL rsp: got id=%0d cos=%0d sin=%0d err=%0d expected id=%0d cos=%0d sin=%0d err=%0d",
                             rsp_id, $signed(rsp_cos), $signed(rsp_sin), rsp_err,
                             mon_e.id, mon_e.cos_v, mon_e.sin_v, mon_e.err);
                end
            end
        end
        if (rst_n) begin
            checks++;
            if ($countones(req_ready) > 1) begin
                errors++;
                $display("FAIL ready_onehot: got req_ready=%b expected at most one bit", req_ready);
            end
        end
    end

    // Raise a request, wait for its grant, optionally expect a response
    task automatic issue(input int id, input int ang, input int c, input int s,
                         input int e, input bit keep);
        bit got;
        got = 1'b0;
        req_angle[id*int'(AW) +: AW] = AW'(ang);
        req_valid[id] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: requester %0d got no req_ready, expected a grant", id);
            req_valid[id] = 1'b0;
            return;
        end
        if (keep) sb.push_back('{id, c, s, e});
        grant_log.push_back(id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_latency(input string name, input int exp);
        int lat;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        check(name, lat, exp);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_order[6];
        exp_order = '{0, 1, 0, 1, 0, 1};
        rst_n     = 1'b0;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_id",    int'(rsp_id), 0);
        check("reset_rsp_cos",   int'($signed(rsp_cos)), 0);
        check("reset_rsp_sin",   int'($signed(rsp_sin)), 0);
        check("reset_rsp_err",   int'(rsp_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic 30 degrees, latency 3
        issue(0, 30, 14189, 8192, 0, 1'b1);
        wait_latency("lat_normal", 3);
        drain();

        // 2: quadrant and wrap angles
        issue(0, 0,   16384, 0,      0, 1'b1);
        issue(0, 90,  0,     16384,  0, 1'b1);
        issue(0, 270, 0,     -16384, 0, 1'b1);
        issue(0, 359, 16382, -286,   0, 1'b1);
        drain();

        // 5: out-of-range angle, latency 1 (leaves rr_ptr at 0)
        issue(1, 400, 0, 0, 1, 1'b1);
        wait_latency("lat_err", 1);
        drain();

        // 3: both requesters held valid, alternating grants
        grant_log.delete();
        fork
            begin
                issue(0, 0,   16384, 0,      0, 1'b1);
                issue(0, 30,  14189, 8192,   0, 1'b1);
                issue(0, 270, 0,     -16384, 0, 1'b1);
            end
            begin
                issue(1, 90,  0,     16384,  0, 1'b1);
                issue(1, 60,  8192,  14189,  0, 1'b1);
                issue(1, 359, 16382, -286,   0, 1'b1);
            end
        join
        drain();
        check("grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check($sformatf("grant_order[%0d]", i), grant_log[i], exp_order[i]);
        end

        // 4: back-pressure holds the response and blocks new grants
        rsp_ready = 1'b0;
        issue(0, 30, 14189, 8192, 0, 1'b1);
        wait_latency("lat_stall", 3);
        req_angle[AW +: AW] = AW'(0);
        req_valid[1] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("stall_valid", int'(rsp_valid), 1);
            check("stall_cos",   int'($signed(rsp_cos)), 14189);
            check("stall_sin",   int'($signed(rsp_sin)), 8192);
            check("stall_id",    int'(rsp_id), 0);
            check("stall_ready", int'(req_ready), 0);
        end
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", int'(rsp_valid), 0);
        drain();

        // 6: reset during SIN abandons the request (rr_ptr was 1)
        issue(0, 30, 0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rr_ptr", int'(dut.rr_ptr), 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_rsp", int'(rsp_valid), 0);
        issue(1, 60, 8192, 14189, 0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
